bp_fe_bht_updater: RTL

BP_FE_BHT_UPDATER -- requirements
Module: bp_fe_bht_updater

---
 rtl/bp_fe_bht_updater.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bp_fe_bht_updater.sv
// bp_fe_bht_updater: in-order FIFO of in-flight branch predictions.
// Each prediction pushes {bht index, predicted direction}. Each resolution
// pops the oldest entry and, one cycle later, emits a BHT update write that
// says whether the prediction was correct.
// Optional feature: define BP_FE_BHT_UPDATER_STATS_EN to add a saturating
// 16-bit mispredict counter. Without it, mispredict_cnt_o is tied to 0.
module bp_fe_bht_updater #(
    parameter bht_idx_width_p = "inv",
    parameter depth_p         = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          pred_v_i,
    input  logic [bht_idx_width_p-1:0]    pred_idx_i,
    input  logic                          pred_taken_i,
    output logic                          pred_ready_o,
    input  logic                          res_v_i,
    input  logic                          res_taken_i,
    input  logic                          flush_i,
    output logic                          w_v_o,
    output logic [bht_idx_width_p-1:0]    idx_w_o,
    output logic                          correct_o,
    output logic [$clog2(depth_p):0]      count_o,
    output logic                          err_o,
    output logic [15:0]                   mispredict_cnt_o
);

    localparam int idx_w_lp = $clog2(depth_p);
    localparam int ptr_w_lp = idx_w_lp + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [ptr_w_lp-1:0]        head_q, head_d;
    logic [ptr_w_lp-1:0]        tail_q, tail_d;
    logic                       w_v_q, w_v_d;
    logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
    logic                       correct_q, correct_d;
    logic                       err_q, err_d;

    // Entry storage is data only; it is never reset.
    logic [bht_idx_width_p-1:0] mem_idx_q   [depth_p];
    logic                       mem_taken_q [depth_p];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (head_q[idx_w_lp-1:0] == tail_q[idx_w_lp-1:0])
                && (head_q[ptr_w_lp-1] != tail_q[ptr_w_lp-1]);
    assign empty = (head_q == tail_q);

    // Flush takes priority: it suppresses both the push and the pop.
    assign push = pred_v_i && !full  && !flush_i;
    assign pop  = res_v_i  && !empty && !flush_i;

    assign pred_ready_o = !full;
    assign count_o      = tail_q - head_q;
    assign w_v_o        = w_v_q;
    assign idx_w_o      = idx_w_q;
    assign correct_o    = correct_q;
    assign err_o        = err_q;

    // Next-state for pointers, the registered update write and the sticky error.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        w_v_d     = 1'b0;
        idx_w_d   = idx_w_q;
        correct_d = correct_q;
        err_d     = err_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d    = head_q + 1'b1;
                w_v_d     = 1'b1;
                idx_w_d   = mem_idx_q[head_q[idx_w_lp-1:0]];
                correct_d = (mem_taken_q[head_q[idx_w_lp-1:0]] == res_taken_i);
            end
            if (res_v_i && empty) begin
                err_d = 1'b1;
            end
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            w_v_q     <= 1'b0;
            idx_w_q   <= '0;
            correct_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            w_v_q     <= w_v_d;
            idx_w_q   <= idx_w_d;
            correct_q <= correct_d;
            err_q     <= err_d;
        end
    end

    // Write the new prediction into the tail slot.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_idx_q[tail_q[idx_w_lp-1:0]]   <= pred_idx_i;
            mem_taken_q[tail_q[idx_w_lp-1:0]] <= pred_taken_i;
        end
    end

`ifdef BP_FE_BHT_UPDATER_STATS_EN
    logic [15:0] mis_cnt_q, mis_cnt_d;

    // Count each visible mispredict update, saturating at all-ones.
    always_comb begin
        mis_cnt_d = mis_cnt_q;
        if (w_v_q && !correct_q && (mis_cnt_q != 16'hFFFF)) begin
            mis_cnt_d = mis_cnt_q + 16'd1;
        end
    end

    // Mispredict counter register; flush deliberately leaves it alone.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mis_cnt_q <= '0;
        end else begin
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign mispredict_cnt_o = mis_cnt_q;
`else
    assign mispredict_cnt_o = 16'd0;
`endif

endmodule
